// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage: state encoding, word width,
// reset/flush instruction and HLT opcode.
package fetch_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] RESET_PC_DEF    = 16'h0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF   = 16'h0000;
    localparam logic [3:0]        HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MISS,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

    function automatic logic is_halt(input logic [WORD_W-1:0] instr,
                                     input logic [3:0]        opcode);
        return instr[WORD_W-1 -: 4] == opcode;
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// and a lookahead carry chain between groups.
module cla_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout,
    output logic        Ovfl
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    always_comb begin
        g = A & B;
        p = A ^ B;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = Cin;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        // Group carries seed each nibble; bits inside a nibble ripple locally.
        c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin
                c[i] = grp_c[i/4];
            end
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        c[16] = grp_c[4];
        Sum   = p ^ c[15:0];
        Cout  = c[16];
        Ovfl  = c[16] ^ c[15];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC register, IF/ID register and I-cache request FSM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR   = NOP_INSTR_DEF,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_next,
    input  logic              branch_taken,
    input  logic              stall,
    input  logic              icache_ready,
    input  logic [WORD_W-1:0] icache_data,
    output logic              icache_req,
    output logic [WORD_W-1:0] icache_addr,
    output logic [WORD_W-1:0] pc_curr,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc_plus2,
    output logic              if_id_valid,
    output logic              fetch_halted,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_miss_cycles
);

    fetch_state_e      state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] redir_q;
    logic [WORD_W-1:0] stale_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] pc_plus2_q;
    logic              valid_q;
    logic              halted_q;

    logic [WORD_W-1:0] pc_plus2_d;
    logic              load_fetch;
    logic              hit_halt;
    logic              unused_cout;
    logic              unused_ovfl;

    cla_16bit u_pc_inc (
        .A    (pc_q),
        .B    (16'h0002),
        .Cin  (1'b0),
        .Sum  (pc_plus2_d),
        .Cout (unused_cout),
        .Ovfl (unused_ovfl)
    );

    always_comb begin
        load_fetch = (state_q == ST_RUN || state_q == ST_MISS)
                   && !branch_taken && !stall && icache_ready;
        hit_halt   = is_halt(icache_data, HALT_OPCODE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            redir_q    <= '0;
            stale_q    <= '0;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_MISS: begin
                    if (branch_taken) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        // A redirect with a fill outstanding must wait it out in DRAIN.
                        if (state_q == ST_MISS || !icache_ready) begin
                            stale_q <= pc_q;
                            redir_q <= pc_next;
                            state_q <= ST_DRAIN;
                        end
                        if (state_q == ST_RUN) begin
                            pc_q <= pc_next;
                        end
                    end else if (load_fetch) begin
                        pc_q       <= pc_next;
                        instr_q    <= icache_data;
                        pc_plus2_q <= pc_plus2_d;
                        valid_q    <= 1'b1;
                        if (hit_halt) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else if (state_q == ST_RUN && !stall && !icache_ready) begin
                        state_q <= ST_MISS;
                    end
                end
                ST_DRAIN: begin
                    if (icache_ready) begin
                        pc_q    <= branch_taken ? pc_next : redir_q;
                        state_q <= ST_RUN;
                    end else if (branch_taken) begin
                        redir_q <= pc_next;
                    end
                end
                ST_HALTED: begin
                    if (branch_taken) begin
                        pc_q     <= pc_next;
                        instr_q  <= NOP_INSTR;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        icache_req     = !rst && (state_q != ST_HALTED);
        icache_addr    = (state_q == ST_DRAIN) ? stale_q : pc_q;
        pc_curr        = pc_q;
        if_id_instr    = instr_q;
        if_id_pc_plus2 = pc_plus2_q;
        if_id_valid    = valid_q;
        fetch_halted   = halted_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (load_fetch && fetch_cnt_q != '1) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == ST_MISS || state_q == ST_DRAIN) && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt   = fetch_cnt_q;
    assign perf_miss_cycles = miss_cnt_q;
`else
    assign perf_fetch_cnt   = '0;
    assign perf_miss_cycles = '0;
`endif

endmodule
